// File: rtl/mag_squared_cal.sv
// mag_squared_cal: squared magnitude I^2 + Q^2 of one complex sample
// computed with a single shared iterative shift-add squarer.
//
// Ports:
//   clock        in   single clock, all logic on posedge
//   reset        in   synchronous, active-high reset
//   inputValid   in   dataInI/dataInQ hold a sample
//   inputReady   out  block idle; sample taken on inputValid && inputReady
//   dataInI      in   DATA_WIDTH in-phase sample, two's complement
//   dataInQ      in   DATA_WIDTH quadrature sample, two's complement
//   outputValid  out  one-cycle pulse, outputData holds a new result
//   outputData   out  2*DATA_WIDTH unsigned I^2 + Q^2 (squareRootCal radicand)
//
// Optional feature macro: MAG_SQ_EARLY_ZERO_EN
//   Defined   : a zero |I| skips the I pass, a zero |Q| skips the Q pass.
//   Undefined : every sample takes a fixed 2*DATA_WIDTH cycles.

module mag_squared_cal #(
    parameter int DATA_WIDTH = 71
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inputValid,
    output logic                      inputReady,
    input  logic [DATA_WIDTH-1:0]     dataInI,
    input  logic [DATA_WIDTH-1:0]     dataInQ,
    output logic                      outputValid,
    output logic [2*DATA_WIDTH-1:0]   outputData
);

    localparam int OUT_W = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SQ_I = 2'd1;
    localparam logic [1:0] SQ_Q = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_magI;
    logic [DATA_WIDTH-1:0] r_magQ;
    logic [OUT_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_k;
    logic                  r_outputValid;
    logic [OUT_W-1:0]      r_outputData;
`ifdef MAG_SQ_EARLY_ZERO_EN
    logic                  r_skipQ;
`endif

    logic                  w_idle;
    logic                  w_handshake;
    logic [DATA_WIDTH-1:0] w_absI;
    logic [DATA_WIDTH-1:0] w_absQ;
    logic [DATA_WIDTH-1:0] w_mag;
    logic                  w_bit;
    logic [OUT_W-1:0]      w_addend;
    logic [OUT_W-1:0]      w_acc_next;
    logic                  w_k_last;

    assign w_idle      = (r_state == IDLE);
    assign w_handshake = inputValid && w_idle;

    // |x| of the most-negative value wraps to 2^(W-1), which is exactly
    // the right unsigned magnitude in W bits.
    assign w_absI = dataInI[DATA_WIDTH-1]
                  ? (~dataInI + DATA_WIDTH'(1))
                  : dataInI;
    assign w_absQ = dataInQ[DATA_WIDTH-1]
                  ? (~dataInQ + DATA_WIDTH'(1))
                  : dataInQ;

    // One squarer shared by both passes: the active operand is picked
    // by the state, and bit k of it adds (mag << k) to the accumulator.
    assign w_mag    = (r_state == SQ_I) ? r_magI : r_magQ;
    assign w_bit    = w_mag[r_k];
    assign w_addend = w_bit
                    ? ({{DATA_WIDTH{1'b0}}, w_mag} << r_k)
                    : '0;

    // Max sum is 2^(2W-1), so the 2W-bit accumulator never overflows.
    assign w_acc_next = r_acc + w_addend;
    assign w_k_last   = (r_k == K_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_magI        <= '0;
            r_magQ        <= '0;
            r_acc         <= '0;
            r_k           <= '0;
            r_outputValid <= 1'b0;
            r_outputData  <= '0;
`ifdef MAG_SQ_EARLY_ZERO_EN
            r_skipQ       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_magI  <= w_absI;
                        r_magQ  <= w_absQ;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= SQ_I;
`ifdef MAG_SQ_EARLY_ZERO_EN
                        r_skipQ <= (w_absQ == '0);
                        if (w_absI == '0 && w_absQ == '0) begin
                            // Park on the last Q step of an all-zero
                            // operand: the next edge publishes 0 and
                            // enters DONE, one cycle after capture.
                            r_state <= SQ_Q;
                            r_k     <= K_LAST;
                        end else if (w_absI == '0) begin
                            r_state <= SQ_Q;
                        end
`endif
                    end
                end

                SQ_I: begin
                    r_acc <= w_acc_next;
                    if (w_k_last) begin
                        r_k     <= '0;
                        r_state <= SQ_Q;
`ifdef MAG_SQ_EARLY_ZERO_EN
                        if (r_skipQ) begin
                            r_outputData  <= w_acc_next;
                            r_outputValid <= 1'b1;
                            r_state       <= DONE;
                        end
`endif
                    end else begin
                        r_k <= r_k + K_ONE;
                    end
                end

                SQ_Q: begin
                    r_acc <= w_acc_next;
                    if (w_k_last) begin
                        r_k           <= '0;
                        r_outputData  <= w_acc_next;
                        r_outputValid <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_k <= r_k + K_ONE;
                    end
                end

                DONE: begin
                    r_outputValid <= 1'b0;
                    r_state       <= IDLE;
                end

                default: begin
                    r_outputValid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign inputReady  = w_idle;
    assign outputValid = r_outputValid;
    assign outputData  = r_outputData;

endmodule
